// File: rtl/mlg_cyclic_decoder_pkg.sv
// Shared types, default check masks and helpers
// for the one-step majority-logic cyclic decoder.
package mlg_pkg;

  // (15,7) code: orthogonal checks on bit 14, check 0 in the low bits
  localparam logic [59:0] DEF_MASK_15_4 = {
    15'h4580,
    15'h4045,
    15'h6022,
    15'h5808
  };

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DECODE = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  function automatic logic [4:0] popcount(
    input logic [15:0] v
  );
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++)
      c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/mlg_cyclic_decoder_if.sv
// Word handshake bundle between deframer,
// decoder and information-bit extractor.
interface mlg_cyclic_decoder_if #(
  parameter int N = 15
);

  localparam int NW = $clog2(N + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_word;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_word;
  logic [NW-1:0] out_nerr;
  logic          busy;

  modport master (
    output in_valid,
    output in_word,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_word,
    input  out_nerr,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_word,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_word,
    output out_nerr,
    output busy
  );

endinterface

// File: rtl/mlg_cyclic_decoder_vote.sv
// Combinational majority vote on the MSB of the
// shift register: check sums, popcount, threshold.
module mlg_vote
  import mlg_pkg::*;
#(
  parameter int               N        = 15,
  parameter int               J        = 4,
  parameter logic [J*N-1:0]   CHK_MASK = DEF_MASK_15_4,
  parameter int               THRESH   = J / 2
) (
  input  logic [N-1:0] ct_i,
  output logic         flip_o
);

  localparam int CW = $clog2(J + 1);

  function automatic bit masks_ok();
    for (int j = 0; j < J; j++)
      if (!CHK_MASK[j*N + N - 1])
        return 1'b0;
    return 1'b1;
  endfunction

  if (!masks_ok()) begin : g_bad_mask
    $fatal(1, "mlg_vote: a check mask lacks bit N-1");
  end

  logic [J-1:0]  s;
  logic [CW-1:0] cnt;

  always_comb begin
    s = '0;
    for (int j = 0; j < J; j++)
      s[j] = ^(ct_i & CHK_MASK[j*N +: N]);
  end

  assign cnt    = CW'(popcount(16'(s)));
  assign flip_o = int'(cnt) > THRESH;

endmodule

// File: rtl/mlg_cyclic_decoder.sv
// One-step majority-logic decoder: accept a word,
// rotate-and-correct N times, present the result.
module mlg_cyclic_decoder
  import mlg_pkg::*;
#(
  parameter int             N        = 15,
  parameter int             J        = 4,
  parameter logic [J*N-1:0] CHK_MASK = DEF_MASK_15_4,
  parameter int             THRESH   = J / 2
) (
  input logic                 clk,
  input logic                 rst,
  mlg_cyclic_decoder_if.slave bus
);

  localparam int SW = $clog2(N);
  localparam int NW = $clog2(N + 1);

  state_t        state_q, state_d;
  logic [N-1:0]  ct_q, ct_d;
  logic [SW-1:0] step_q, step_d;
  logic [NW-1:0] nerr_q, nerr_d;
  logic          flip;

  mlg_vote #(
    .N       (N),
    .J       (J),
    .CHK_MASK(CHK_MASK),
    .THRESH  (THRESH)
  ) u_vote (
    .ct_i  (ct_q),
    .flip_o(flip)
  );

  always_comb begin
    state_d = state_q;
    ct_d    = ct_q;
    step_d  = step_q;
    nerr_d  = nerr_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (bus.in_valid) begin
          ct_d    = bus.in_word;
          step_d  = '0;
          nerr_d  = '0;
          state_d = ST_DECODE;
        end
      end
      (state_q == ST_DECODE): begin
        // corrected MSB wraps to bit 0
        ct_d   = {ct_q[N-2:0], ct_q[N-1] ^ flip};
        nerr_d = nerr_q + NW'(flip);
        step_d = step_q + SW'(1);
        if (step_q == SW'(N - 1))
          state_d = ST_DONE;
      end
      (state_q == ST_DONE): begin
        if (bus.out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ct_q    <= '0;
      step_q  <= '0;
      nerr_q  <= '0;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      step_q  <= step_d;
      nerr_q  <= nerr_d;
    end
  end

  assign bus.in_ready  = state_q == ST_IDLE;
  assign bus.out_valid = state_q == ST_DONE;
  assign bus.busy      = state_q != ST_IDLE;
  assign bus.out_word  = ct_q;
  assign bus.out_nerr  = nerr_q;

endmodule

// File: doc/mlg_cyclic_decoder.md
# mlg_cyclic_decoder

Parametrised one-step majority-logic decoder for binary cyclic codes, successor to the fixed (15,7) corrector stage. It accepts a received N-bit word over a valid/ready handshake and performs N cyclic shift-and-correct steps, one per clock, using J orthogonal check sums on the MSB position. It then presents the corrected word and a correction count downstream. It sits between the channel-word deframer and the information-bit extractor in the LDPC/cyclic-code datapath.

## Interface
- N, 15, code length in bits (N ≥ 3).
- J, 4, number of orthogonal check sums (1 ≤ J ≤ 16).
- CHK_MASK, mlg_pkg::DEF_MASK_15_4, J×N-bit packed masks, check j = bits [j*N +: N]; every mask must have bit N-1 set.
- THRESH, J/2, MSB is flipped when the count of failing checks is strictly greater than THRESH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept a word (high only in IDLE).
- in_word  in  N  received codeword, bit N-1 is the first position corrected.
- out_valid  out  1  corrected word available.
- out_ready  in  1  downstream accepts word.
- out_word  out  N  corrected codeword.
- out_nerr  out  $clog2(N+1)  number of bit flips applied to this word.
- busy  out  1  high in DECODE or DONE.

## Operation
- FSM states: IDLE, DECODE, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&in_ready: load shift register ct ← in_word, clear step counter and nerr, go to DECODE.
- DECODE, each cycle:
  - check s_j = XOR of ct bits selected by mask j.
  - cnt = popcount(s), width $clog2(J+1).
  - flip = (cnt > THRESH); cc = ct[N-1] ^ flip.
  - ct ← {ct[N-2:0], cc} (rotate left, corrected MSB wraps to bit 0).
  - nerr ← nerr + flip; step ← step+1.
  - After the N-th step (step == N-1 this cycle), go to DONE; ct is back in original alignment.
- DONE: out_valid=1, out_word=ct, out_nerr=nerr held stable. On out_ready, go to IDLE. No acceptance of a new word in DONE.
- in_valid while busy is ignored (in_ready low), with no side effects.
- rst in any state: return to IDLE in the next cycle; in-flight word discarded.
- Reset values: in_ready=1, out_valid=0, busy=0, out_word=0, out_nerr=0.
- Step counter width $clog2(N); nerr saturates never (max N fits).
- A word beyond correction capability is still processed; output is whatever the algorithm produces, with no error flag.

## Timing
- Acceptance edge t → DECODE steps on edges t+1 … t+N → out_valid high from edge t+N until the out_ready handshake edge.
- Latency in_valid&in_ready to out_valid: N cycles. Minimum word period: N+2 cycles (accept, N steps, unload; in_ready returns the cycle after the unload edge).
- out_valid must not drop without out_ready. out_word and out_nerr must not change while out_valid=1.
- Check-sum, popcount and compare form one combinational path per step, with no pipelining inside DECODE.

## Structure
- Package mlg_pkg: DEF_MASK_15_4 (checks on bits {3,11,12,14}, {1,5,13,14}, {0,2,6,14}, {7,8,10,14}), state enum, popcount function.
- Sub-module mlg_vote (combinational): ct, CHK_MASK, THRESH → flip. The top holds the FSM, shift register and counters.
- Parameter elaboration check: fatal error if any mask lacks bit N-1.

## Test plan
- Defaults, in_word=15'h0000 → after 15 cycles out_word=15'h0000, out_nerr=0.
- in_word=15'h01D1 (generator codeword) with bit 3 flipped (15'h01D9) → out_word=15'h01D1, out_nerr=1, out_valid 15 cycles after accept.
- in_word=15'h7FFF with bits 0 and 9 flipped (15'h7DFE) → out_word=15'h7FFF, out_nerr=2.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 throughout → out_word stable, in_ready=0, no second word accepted. Release → IDLE, then accept the next word one cycle later.
- Assert rst at step 7 of DECODE → next cycle IDLE, in_ready=1, out_valid=0, out_nerr=0. A new word then decodes correctly.
- Back-to-back words with out_ready tied high → accept edges spaced exactly N+2=17 cycles apart.
